// File: rtl/sram_mem_arbiter_pkg.sv
// Shared encodings and parameter defaults for the instruction/data SRAM arbiter.
package sram_mem_arbiter_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_LIM_DEF = 4;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selector: data wins by default, inst wins when alone or when starved.
module sram_arb_pick
  import sram_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic       inst_req,
  input  logic       data_req,
  input  logic [3:0] starve_cnt,
  output logic [1:0] grant
);

  logic inst_force;

  always_comb begin
    inst_force = inst_req && (starve_cnt == 4'(STARVE_LIM));
    grant      = 2'b00;
    if (inst_req && (!data_req || inst_force)) begin
      grant[OWN_INST] = 1'b1;
    end else if (data_req) begin
      grant[OWN_DATA] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_mem_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and load/store channels,
// one access outstanding at a time, with grants allowed on the response cycle.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | nothing outstanding, grant window open
// ST_BUSY | one access outstanding, lat_cnt counts down
module sram_mem_arbiter
  import sram_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t     state, state_nxt;
  logic       owner;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic [1:0] pick;
  logic       resp, window, grant_inst, grant_data, grant_any;

  sram_arb_pick #(
    .STARVE_LIM (STARVE_LIM)
  ) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .starve_cnt (starve_cnt),
    .grant      (pick)
  );

  // Reset gates the handshakes so an access in flight never reports completion.
  always_comb begin
    resp       = !reset && (state == ST_BUSY) && (lat_cnt == 3'd1);
    window     = !reset && ((state == ST_IDLE) || resp);
    grant_inst = window && pick[OWN_INST];
    grant_data = window && pick[OWN_DATA];
    grant_any  = grant_inst || grant_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_INST;
      lat_cnt    <= 3'd0;
      starve_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        owner   <= grant_data ? OWN_DATA : OWN_INST;
        lat_cnt <= 3'(MEM_LAT);
      end else if (state == ST_BUSY) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (grant_inst) begin
        starve_cnt <= 4'd0;
      end else if (grant_data) begin
        if (!inst_req) begin
          starve_cnt <= 4'd0;
        end else if (starve_cnt != 4'(STARVE_LIM)) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_any) state_nxt = ST_BUSY;
      ST_BUSY: if (resp && !grant_any) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    mem_en       = grant_any;
    mem_addr     = grant_inst ? inst_addr : data_addr;
    mem_wen      = (grant_data && data_wr) ? data_wstrb : 4'b0000;
    mem_wdata    = data_wdata;
    inst_data_ok = resp && (owner == OWN_INST);
    data_data_ok = resp && (owner == OWN_DATA);
    inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
    data_rdata   = data_data_ok ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Self-checking bench: three arbiters (MEM_LAT 1/2/3) with directed scenarios and
// randomized traffic checked against a time-based scheduling model.
module tb_sram_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req     [3];
  logic [31:0] inst_addr    [3];
  logic        inst_addr_ok [3];
  logic        inst_data_ok [3];
  logic [31:0] inst_rdata   [3];
  logic        data_req     [3];
  logic        data_wr      [3];
  logic [3:0]  data_wstrb   [3];
  logic [31:0] data_addr    [3];
  logic [31:0] data_wdata   [3];
  logic        data_addr_ok [3];
  logic        data_data_ok [3];
  logic [31:0] data_rdata   [3];
  logic        mem_en       [3];
  logic [3:0]  mem_wen      [3];
  logic [31:0] mem_addr     [3];
  logic [31:0] mem_wdata    [3];
  logic [31:0] mem_rdata    [3];
  logic [31:0] dl           [3][4];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_mem_arbiter #(
      .MEM_LAT    (g + 1),
      .STARVE_LIM ((g == 2) ? 2 : 4)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req[g]),
      .inst_addr    (inst_addr[g]),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .inst_rdata   (inst_rdata[g]),
      .data_req     (data_req[g]),
      .data_wr      (data_wr[g]),
      .data_wstrb   (data_wstrb[g]),
      .data_addr    (data_addr[g]),
      .data_wdata   (data_wdata[g]),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .data_rdata   (data_rdata[g]),
      .mem_en       (mem_en[g]),
      .mem_wen      (mem_wen[g]),
      .mem_addr     (mem_addr[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_rdata    (mem_rdata[g])
    );
    assign mem_rdata[g] = dl[g][g];
  end

  function automatic int lat_of(input int d);
    return d + 1;
  endfunction

  function automatic int lim_of(input int d);
    return (d == 2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_BFAF;
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  // SRAM stand-in: read data appears MEM_LAT cycles after mem_en, stores read back 0.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int k = 3; k > 0; k--) dl[d][k] <= reset ? 32'd0 : dl[d][k-1];
      dl[d][0] <= (!reset && mem_en[d] && mem_wen[d] == 4'b0) ? mem_fn(mem_addr[d]) : 32'd0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        inst_req[d] = 1'b0;
        data_req[d] = 1'b0;
      end
    end
  endtask

  function automatic logic [8:0] ctl(input int d);
    return {inst_addr_ok[d], data_addr_ok[d], inst_data_ok[d], data_data_ok[d],
            mem_en[d], mem_wen[d]};
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      inst_req[d] = 0; inst_addr[d] = 0; data_req[d] = 0; data_wr[d] = 0;
      data_wstrb[d] = 0; data_addr[d] = 0; data_wdata[d] = 0;
    end
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (ctl(d) !== 9'd0 || inst_rdata[d] !== 32'd0 || data_rdata[d] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_outputs d=%0d ctl=%b irdata=%h drdata=%h required all zero",
                 d, ctl(d), inst_rdata[d], data_rdata[d]);
      end
    end
  endtask

  task automatic test_single_inst();
    for (int c = 0; c < 5; c++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        inst_req[d] = (c == 0);
        inst_addr[d] = 32'hBFC0_0000;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        logic [8:0] ev;
        ev = {c == 0, 1'b0, c == lat_of(d), 1'b0, c == 0, 4'b0000};
        n_chk++;
        if (ctl(d) !== ev) begin
          n_fail++;
          $display("FAIL single_inst_ctl d=%0d c=%0d got=%b exp=%b", d, c, ctl(d), ev);
        end
        if (c == 0) begin
          n_chk++;
          if (mem_addr[d] !== 32'hBFC0_0000) begin
            n_fail++;
            $display("FAIL single_inst_addr d=%0d got=%h exp=bfc00000", d, mem_addr[d]);
          end
        end
        if (c == lat_of(d)) begin
          n_chk++;
          if (inst_rdata[d] !== 32'h3C08_BFAF) begin
            n_fail++;
            $display("FAIL single_inst_rdata d=%0d got=%h exp=3c08bfaf", d, inst_rdata[d]);
          end
        end
      end
    end
  endtask

  task automatic test_store();
    for (int c = 0; c < 5; c++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        data_req[d] = (c == 0); data_wr[d] = 1'b1; data_wstrb[d] = 4'b0011;
        data_addr[d] = 32'h8000_1000; data_wdata[d] = 32'h1234_5678;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        logic [8:0] ev;
        ev = {1'b0, c == 0, 1'b0, c == lat_of(d), c == 0, (c == 0) ? 4'b0011 : 4'b0000};
        n_chk++;
        if (ctl(d) !== ev) begin
          n_fail++;
          $display("FAIL store_ctl d=%0d c=%0d got=%b exp=%b", d, c, ctl(d), ev);
        end
        if (c == 0) begin
          n_chk++;
          if (mem_addr[d] !== 32'h8000_1000 || mem_wdata[d] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL store_bus d=%0d addr=%h wdata=%h exp 80001000/12345678",
                     d, mem_addr[d], mem_wdata[d]);
          end
        end
        if (c == lat_of(d)) begin
          n_chk++;
          if (data_rdata[d] !== 32'd0) begin
            n_fail++;
            $display("FAIL store_rdata d=%0d got=%h exp=0", d, data_rdata[d]);
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) data_wr[d] = 1'b0;
  endtask

  task automatic test_conflict();
    for (int c = 0; c < 9; c++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        inst_req[d] = (c <= lat_of(d)); inst_addr[d] = 32'hBFC0_0010;
        data_req[d] = (c == 0); data_wr[d] = 1'b0; data_addr[d] = 32'h8000_2000;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        logic [8:0] ev;
        int l;
        l = lat_of(d);
        ev = {c == l, c == 0, c == 2 * l, c == l, (c == 0) || (c == l), 4'b0000};
        n_chk++;
        if (ctl(d) !== ev) begin
          n_fail++;
          $display("FAIL conflict_ctl d=%0d c=%0d got=%b exp=%b", d, c, ctl(d), ev);
        end
        if (c == l) begin
          n_chk++;
          if (data_rdata[d] !== mem_fn(32'h8000_2000) || mem_addr[d] !== 32'hBFC0_0010) begin
            n_fail++;
            $display("FAIL conflict_swap d=%0d drdata=%h maddr=%h exp %h/bfc00010",
                     d, data_rdata[d], mem_addr[d], mem_fn(32'h8000_2000));
          end
        end
        if (c == 2 * l) begin
          n_chk++;
          if (inst_rdata[d] !== mem_fn(32'hBFC0_0010)) begin
            n_fail++;
            $display("FAIL conflict_irdata d=%0d got=%h exp=%h", d, inst_rdata[d],
                     mem_fn(32'hBFC0_0010));
          end
        end
      end
    end
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 30; c++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        inst_req[d] = 1'b1; inst_addr[d] = 32'hBFC0_0020;
        data_req[d] = 1'b1; data_wr[d] = 1'b0; data_addr[d] = 32'h8000_3000;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        logic ei, ed;
        int l, k;
        l = lat_of(d);
        k = c / l;
        ei = (c % l == 0) && (k % (lim_of(d) + 1) == lim_of(d));
        ed = (c % l == 0) && !ei;
        n_chk++;
        if (inst_addr_ok[d] !== ei || data_addr_ok[d] !== ed || mem_en[d] !== (ei | ed)) begin
          n_fail++;
          $display("FAIL starve_grant d=%0d c=%0d got i=%b d=%b en=%b exp i=%b d=%b",
                   d, c, inst_addr_ok[d], data_addr_ok[d], mem_en[d], ei, ed);
        end
        if (ei || ed) begin
          n_chk++;
          if (mem_addr[d] !== (ei ? 32'hBFC0_0020 : 32'h8000_3000)) begin
            n_fail++;
            $display("FAIL starve_addr d=%0d c=%0d got=%h", d, c, mem_addr[d]);
          end
        end
      end
    end
    idle(8);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 12; c++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        int kn;
        kn = (c + lat_of(d) - 1) / lat_of(d);
        data_req[d] = (kn < 3); data_wr[d] = 1'b0;
        data_addr[d] = 32'h8000_0100 + 32'(kn * 4 + d * 64);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        logic eg, er;
        int l;
        l = lat_of(d);
        eg = (c % l == 0) && (c < 3 * l);
        er = (c % l == 0) && (c > 0) && (c <= 3 * l);
        n_chk++;
        if (data_addr_ok[d] !== eg || data_data_ok[d] !== er || inst_data_ok[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ctl d=%0d c=%0d got aok=%b dok=%b exp aok=%b dok=%b",
                   d, c, data_addr_ok[d], data_data_ok[d], eg, er);
        end
        if (er) begin
          logic [31:0] ea;
          ea = 32'h8000_0100 + 32'((c / l - 1) * 4 + d * 64);
          n_chk++;
          if (data_rdata[d] !== mem_fn(ea)) begin
            n_fail++;
            $display("FAIL b2b_rdata d=%0d c=%0d got=%h exp=%h", d, c, data_rdata[d], mem_fn(ea));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 8; c++) begin
      step();
      reset = (c == 1);
      for (int d = 0; d < 3; d++) begin
        inst_req[d] = (c == 0); inst_addr[d] = 32'hBFC0_0040; data_req[d] = 1'b0;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        logic [8:0] ev;
        ev = (c == 0) ? 9'b1_0000_0000 | 9'b0_0001_0000 : 9'd0;
        n_chk++;
        if (ctl(d) !== ev || inst_rdata[d] !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_mid d=%0d c=%0d got=%b irdata=%h exp=%b irdata=0",
                   d, c, ctl(d), inst_rdata[d], ev);
        end
      end
    end
  endtask

  task automatic test_random();
    bit          r_valid [3];
    bit          r_ch    [3];
    int          r_due   [3];
    logic [31:0] r_data  [3];
    int          starve  [3];
    bit          i_act   [3];
    bit          d_act   [3];
    for (int d = 0; d < 3; d++) begin
      r_valid[d] = 0; starve[d] = 0; i_act[d] = 0; d_act[d] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        if (!i_act[d] && $urandom_range(0, 1) == 1) begin
          i_act[d] = 1;
          inst_addr[d] = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_act[d] && $urandom_range(0, 3) != 0) begin
          d_act[d] = 1;
          data_wr[d] = 1'($urandom_range(0, 1));
          data_wstrb[d] = 4'($urandom_range(1, 15));
          data_addr[d] = $urandom;
          data_wdata[d] = $urandom;
        end
        inst_req[d] = i_act[d];
        data_req[d] = d_act[d];
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        logic       ex_resp, win, gi, gd;
        logic [8:0] ev;
        ex_resp = r_valid[d] && (r_due[d] == c);
        win = !r_valid[d] || ex_resp;
        gi = win && inst_req[d] && (!data_req[d] || starve[d] == lim_of(d));
        gd = win && data_req[d] && !gi;
        ev = {gi, gd, ex_resp && !r_ch[d], ex_resp && r_ch[d], gi || gd,
              (gd && data_wr[d]) ? data_wstrb[d] : 4'b0000};
        n_chk++;
        if (ctl(d) !== ev) begin
          n_fail++;
          $display("FAIL rand_ctl d=%0d c=%0d got=%b exp=%b", d, c, ctl(d), ev);
        end
        if (gi || gd) begin
          n_chk++;
          if (mem_addr[d] !== (gi ? inst_addr[d] : data_addr[d]) ||
              (gd && data_wr[d] && mem_wdata[d] !== data_wdata[d])) begin
            n_fail++;
            $display("FAIL rand_bus d=%0d c=%0d addr=%h wdata=%h", d, c, mem_addr[d], mem_wdata[d]);
          end
        end
        if (ex_resp) begin
          n_chk++;
          if ((r_ch[d] ? data_rdata[d] : inst_rdata[d]) !== r_data[d]) begin
            n_fail++;
            $display("FAIL rand_rdata d=%0d c=%0d ch=%0d got=%h exp=%h", d, c, r_ch[d],
                     r_ch[d] ? data_rdata[d] : inst_rdata[d], r_data[d]);
          end
          r_valid[d] = 0;
        end
        if (gi || gd) begin
          r_valid[d] = 1;
          r_due[d] = c + lat_of(d);
          r_ch[d] = gd;
          r_data[d] = gi ? mem_fn(inst_addr[d]) : (data_wr[d] ? 32'd0 : mem_fn(data_addr[d]));
        end
        if (gi) begin
          starve[d] = 0;
          i_act[d] = 0;
        end
        if (gd) begin
          starve[d] = inst_req[d] ? ((starve[d] < lim_of(d)) ? starve[d] + 1 : starve[d]) : 0;
          d_act[d] = 0;
        end
      end
    end
    idle(6);
  endtask

  initial begin
    test_reset();
    test_single_inst();
    idle(3);
    test_store();
    idle(3);
    test_conflict();
    idle(3);
    test_starvation();
    test_back_to_back();
    idle(3);
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
